// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_mem_pkg
// Description : Shared definitions for the MEM-stage SRAM controller:
//               controller state encoding, external SRAM bus widths,
//               default base address and the byte-address-to-word helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

    localparam int C_SRAM_DATA_W = 16;
    localparam int C_SRAM_ADDR_W = 18;
    localparam int C_WORD_IDX_W  = C_SRAM_ADDR_W - 1;
    localparam int C_WAIT_W      = 4;

    localparam logic [31:0] C_BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    // 32-bit word index relative to the SRAM window. The subtraction wraps
    // modulo 2^32 and only the low index bits reach the SRAM, so addresses
    // outside the window alias silently.
    function automatic logic [C_WORD_IDX_W-1:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        logic [31:0] w_offset;
        w_offset   = addr - base;
        word_index = w_offset[C_WORD_IDX_W+1:2];
    endfunction

endpackage : arm_mem_pkg
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_counter
// Description : Wait-state down-counter. load has priority over enable;
//               enable decrements while the count is non-zero. zero flags
//               the final cycle of the current wait period.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               load,load_value - reload the counter
//               enable          - decrement by one (saturates at zero)
//               zero            - count equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : MEM-stage bridge from a 32-bit load/store request to a
//               16-bit asynchronous SRAM. Each access is split into a LOW
//               and a HIGH half-word phase, each WAIT_CYCLES long, followed
//               by a single DONE cycle. ready stalls the pipeline meanwhile.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               wr_en, rd_en        - store / load request (store wins)
//               address, write_data - byte address and store data
//               read_data           - registered load result
//               ready               - 1 when idle or access complete
//               sram_dq/addr/we_n/oe_n - external SRAM interface
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = C_BASE_ADDR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    inout  wire  [C_SRAM_DATA_W-1:0] sram_dq,
    output logic [C_SRAM_ADDR_W-1:0] sram_addr,
    output logic                     sram_we_n,
    output logic                     sram_oe_n
);

    localparam logic [C_WAIT_W-1:0] C_WAIT_LOAD = C_WAIT_W'(WAIT_CYCLES - 1);

    mem_state_t                r_state;
    logic                      r_is_write;
    logic [C_WORD_IDX_W-1:0]   r_index;
    logic [15:0]               r_wdata_hi;
    logic [15:0]               r_low_half;
    logic [31:0]               r_read_data;
    logic [C_SRAM_ADDR_W-1:0]  r_sram_addr;
    logic                      r_we_n;
    logic                      r_oe_n;
    logic                      r_dq_oe;
    logic [C_SRAM_DATA_W-1:0]  r_dq_out;

    logic                      w_req;
    logic [C_WORD_IDX_W-1:0]   w_index;
    logic                      w_cnt_load;
    logic                      w_cnt_en;
    logic                      w_cnt_zero;

    assign w_req   = rd_en | wr_en;
    assign w_index = word_index(address, BASE_ADDR);

    // The counter holds the remaining cycles after the current one, so zero
    // marks the last cycle of a phase; it is reloaded on entry to each phase.
    assign w_cnt_load = ((r_state == ST_IDLE) && w_req) ||
                        ((r_state == ST_LOW)  && w_cnt_zero);
    assign w_cnt_en   = (r_state == ST_LOW) || (r_state == ST_HIGH);

    sram_wait_counter #(
        .WIDTH (C_WAIT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (w_cnt_load),
        .load_value (C_WAIT_LOAD),
        .enable     (w_cnt_en),
        .zero       (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_is_write  <= 1'b0;
            r_index     <= '0;
            r_wdata_hi  <= '0;
            r_low_half  <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        // A simultaneous read+write request is a write.
                        r_is_write  <= wr_en;
                        r_index     <= w_index;
                        r_wdata_hi  <= write_data[31:16];
                        r_sram_addr <= {w_index, 1'b0};
                        r_we_n      <= ~wr_en;
                        r_oe_n      <= wr_en;
                        r_dq_oe     <= wr_en;
                        r_dq_out    <= write_data[15:0];
                        r_state     <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_cnt_zero) begin
                        // Low half is staged so read_data only ever changes
                        // once the whole word has been fetched.
                        if (!r_is_write) begin
                            r_low_half <= sram_dq;
                        end
                        r_sram_addr <= {r_index, 1'b1};
                        r_dq_out    <= r_wdata_hi;
                        r_state     <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_cnt_zero) begin
                        if (!r_is_write) begin
                            r_read_data <= {sram_dq, r_low_half};
                        end
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == ST_DONE) || ((r_state == ST_IDLE) && !w_req);
    assign read_data = r_read_data;
    assign sram_addr = r_sram_addr;
    assign sram_we_n = r_we_n;
    assign sram_oe_n = r_oe_n;
    assign sram_dq   = r_dq_oe ? r_dq_out : {C_SRAM_DATA_W{1'bz}};

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Scoreboard testbench for sram_controller. A driver issues
//               directed and random accesses and pushes expected results
//               computed from a word-level memory model; a monitor pops and
//               compares whenever an access completes (ready returns high).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          LAT  = 2 * W + 1;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;

    sram_controller #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_dq    (sram_dq),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external SRAM model (half-word array) ----------------
    logic [15:0] sram_mem [0:262143];
    initial for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
    assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        bit          is_wr;
        logic [16:0] idx;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } txn_t;

    txn_t        exp_q[$];
    bit   [31:0] ref_mem [int];
    logic [31:0] cur_rd;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [16:0] ref_index(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE) / 4;
        return off[16:0];
    endfunction

    // ---------------- monitor ----------------
    initial begin
        int   run;
        txn_t e;
        logic [17:0] ea;
        run = 0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                exp_q.delete();
                run = 0;
                continue;
            end
            if (!ready) begin
                run++;
                if (run >= 2 && run <= LAT && exp_q.size() > 0) begin
                    e  = exp_q[0];
                    ea = (run - 1 <= W) ? {e.idx, 1'b0} : {e.idx, 1'b1};
                    check("sram_addr", {14'd0, sram_addr}, {14'd0, ea});
                    check("we_n", {31'd0, sram_we_n}, {31'd0, !e.is_wr});
                    check("oe_n", {31'd0, sram_oe_n}, {31'd0, e.is_wr});
                    if (e.is_wr)
                        check("dq_drive", {16'd0, sram_dq},
                              {16'd0, (run - 1 <= W) ? e.wdata[15:0] : e.wdata[31:16]});
                end
            end else begin
                if (run > 0) begin
                    check("latency", run, LAT);
                    if (exp_q.size() == 0) begin
                        check("queue_nonempty", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("read_data", read_data, e.exp_rd);
                        if (e.is_wr)
                            check("sram_word", {sram_mem[{e.idx, 1'b1}], sram_mem[{e.idx, 1'b0}]}, e.wdata);
                    end
                    run = 0;
                end else begin
                    check("idle_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at negedge+1; in_done says the DUT is currently in DONE, so the
    // request is held across the DONE edge and taken in the following IDLE.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit in_done);
        txn_t t;
        bit   done;
        t.is_wr = wr;
        t.idx   = ref_index(addr);
        t.wdata = data;
        if (wr) ref_mem[int'(t.idx)] = data;
        else    cur_rd = ref_mem.exists(int'(t.idx)) ? ref_mem[int'(t.idx)] : 32'd0;
        t.exp_rd = cur_rd;
        exp_q.push_back(t);
        rd_en = rd; wr_en = wr; address = addr; write_data = data;
        repeat (in_done ? 2 : 1) @(posedge clk);
        done = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (k <= 2 * W - 1) begin
                rd_en = 1'($urandom); wr_en = 1'($urandom);
                address = $urandom; write_data = $urandom;
            end else begin
                rd_en = 1'b0; wr_en = 1'b0;
            end
            #1;
            if (ready) done = 1;
        end
        if (!done) check("ready_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        bit          b2b;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        cur_rd = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_read_data", read_data, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        // directed accesses
        do_txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
        check("sram0", {16'd0, sram_mem[0]}, 32'h0000BEEF);
        check("sram1", {16'd0, sram_mem[1]}, 32'h0000DEAD);
        do_txn(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
        check("rd_deadbeef", read_data, 32'hDEADBEEF);
        do_txn(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b1);
        check("sram2", {16'd0, sram_mem[2]}, 32'h00005678);
        check("sram3", {16'd0, sram_mem[3]}, 32'h00001234);
        do_txn(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 1'b1);
        check("both_rd_hold", read_data, 32'hDEADBEEF);
        check("sram5_4", {sram_mem[5], sram_mem[4]}, 32'hA5A5A5A5);

        // random accesses, mixing back-to-back and idle gaps
        b2b = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (!b2b) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1;
            end
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
            do_txn(op == 1 || op == 2 || op == 3, op == 0 || op == 2, a, $urandom, b2b);
            b2b = 1'($urandom);
        end

        // reset during HIGH of a read
        @(negedge clk); #1;
        do_txn(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0);
        do_txn(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
        check("rd_cafe", read_data, 32'hCAFEF00D);
        @(negedge clk); #1;
        rd_en = 1'b1; address = 32'd1024;
        @(posedge clk);
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        cur_rd = '0;
        check("abort_read_data", read_data, 32'd0);
        check("abort_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        check("abort_addr", {14'd0, sram_addr}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_dq_hiz", {31'd0, dut.r_dq_oe}, 32'd0);

        // idle window
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("idle_ready", {31'd0, ready}, 32'd1);
        end
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_sram_controller
`default_nettype wire
